// File: rtl/pid_cmd_parser.sv
// UART command parser: assembles SYNC/CMD/DHI/DLO/CSUM frames into the PID tuning
// registers and answers each complete frame with an ACK/NAK byte via the transmitter.
`timescale 1ns/1ps
module pid_cmd_parser #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [15:0] KP_INIT        = 16'h0000,
  parameter logic [15:0] KI_INIT        = 16'h0000,
  parameter logic [15:0] KD_INIT        = 16'h0000,
  parameter logic [15:0] SP_INIT        = 16'h0000
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [7:0]  rx_byte,
  input  logic        rx_rdy,
  input  logic        send_rdy,
  output logic        send,
  output logic [7:0]  send_data,
  output logic [15:0] kp,
  output logic [15:0] ki,
  output logic [15:0] kd,
  output logic [15:0] setpoint,
  output logic        param_upd,
  output logic        frame_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_DHI, S_DLO, S_CSUM, S_ACK_WAIT, S_ACK_SEND
  } state_e;

  state_e            state_q, state_d;
  logic              rx_rdy_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        cmd_q, dhi_q, dlo_q;
  logic [7:0]        send_data_q;
  logic [15:0]       kp_q, ki_q, kd_q, sp_q;
  logic              param_upd_q, frame_err_q;

  logic strobe;
  logic timeout;
  logic in_frame;
  logic eval;
  logic frame_good;
  logic frame_timeout;

  // A held rx_rdy level produces exactly one strobe on its rising edge.
  assign strobe        = rx_rdy & ~rx_rdy_q;
  assign timeout       = (state_q != S_IDLE) && (cnt_q == CNT_MAX);
  assign in_frame      = (state_q == S_CMD) || (state_q == S_DHI) ||
                         (state_q == S_DLO) || (state_q == S_CSUM);
  assign eval          = (state_q == S_CSUM) && strobe;
  assign frame_good    = (rx_byte == (cmd_q ^ dhi_q ^ dlo_q)) &&
                         (cmd_q inside {8'h01, 8'h02, 8'h03, 8'h04});
  assign frame_timeout = in_frame && !strobe && timeout;

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (strobe && (rx_byte == SYNC_BYTE)) state_d = S_CMD;
      S_CMD:      if (strobe) state_d = S_DHI;      else if (timeout) state_d = S_IDLE;
      S_DHI:      if (strobe) state_d = S_DLO;      else if (timeout) state_d = S_IDLE;
      S_DLO:      if (strobe) state_d = S_CSUM;     else if (timeout) state_d = S_IDLE;
      S_CSUM:     if (strobe) state_d = S_ACK_WAIT; else if (timeout) state_d = S_IDLE;
      S_ACK_WAIT: if (timeout) state_d = S_IDLE;    else if (send_rdy) state_d = S_ACK_SEND;
      S_ACK_SEND: if (timeout || !send_rdy) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    send      = (state_q == S_ACK_SEND);
    send_data = send_data_q;
    kp        = kp_q;
    ki        = ki_q;
    kd        = kd_q;
    setpoint  = sp_q;
    param_upd = param_upd_q;
    frame_err = frame_err_q;
  end

  // Inactivity counter restarts on every byte and every state change.
  always_comb begin
    cnt_d = cnt_q;
    if (strobe || (state_d != state_q) || (state_q == S_IDLE)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      rx_rdy_q    <= 1'b0;
      cnt_q       <= '0;
      cmd_q       <= 8'h00;
      dhi_q       <= 8'h00;
      dlo_q       <= 8'h00;
      send_data_q <= 8'h00;
      kp_q        <= KP_INIT;
      ki_q        <= KI_INIT;
      kd_q        <= KD_INIT;
      sp_q        <= SP_INIT;
      param_upd_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_rdy_q    <= rx_rdy;
      cnt_q       <= cnt_d;
      param_upd_q <= eval && frame_good;
      frame_err_q <= (eval && !frame_good) || frame_timeout;
      if (strobe) begin
        case (state_q)
          S_CMD:   cmd_q <= rx_byte;
          S_DHI:   dhi_q <= rx_byte;
          S_DLO:   dlo_q <= rx_byte;
          default: ;
        endcase
      end
      if (eval) begin
        send_data_q <= frame_good ? ACK_BYTE : NAK_BYTE;
        if (frame_good) begin
          case (cmd_q)
            8'h01:   kp_q <= {dhi_q, dlo_q};
            8'h02:   ki_q <= {dhi_q, dlo_q};
            8'h03:   kd_q <= {dhi_q, dlo_q};
            8'h04:   sp_q <= {dhi_q, dlo_q};
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_pid_cmd_parser.sv
// Self-checking bench for pid_cmd_parser: byte-level frame model, transmitter model,
// directed scenarios plus randomized frames.
`timescale 1ns/1ps
module tb_pid_cmd_parser;

  localparam int TMO = 100;

  logic        clk_in = 1'b0;
  logic        reset;
  logic [7:0]  rx_byte;
  logic        rx_rdy;
  logic        send_rdy;
  logic        send;
  logic [7:0]  send_data;
  logic [15:0] kp, ki, kd, setpoint;
  logic        param_upd, frame_err;

  pid_cmd_parser #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_in(clk_in), .reset(reset), .rx_byte(rx_byte), .rx_rdy(rx_rdy),
    .send_rdy(send_rdy), .send(send), .send_data(send_data),
    .kp(kp), .ki(ki), .kd(kd), .setpoint(setpoint),
    .param_upd(param_upd), .frame_err(frame_err)
  );

  always #5 clk_in = ~clk_in;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  // Reference model state
  logic [7:0]  mfrm[$];
  logic [15:0] m_reg[4];
  int          exp_upd = 0;
  int          exp_err = 0;
  logic [7:0]  exp_acks[$];

  // Observed behaviour
  int          upd_cnt = 0;
  int          err_cnt = 0;
  int          both_cnt = 0;
  int          send_cycles = 0;
  logic [7:0]  got_acks[$];
  bit          tx_auto = 1'b1;
  int          tx_busy = 0;

  function automatic bit model_byte(input logic [7:0] b);
    logic [7:0] c, h, l, s;
    if (mfrm.size() == 0) begin
      if (b == 8'hA5) mfrm.push_back(b);
      return 1'b0;
    end
    mfrm.push_back(b);
    if (mfrm.size() < 5) return 1'b0;
    c = mfrm[1]; h = mfrm[2]; l = mfrm[3]; s = mfrm[4];
    mfrm.delete();
    if (((c ^ h ^ l) == s) && (c >= 8'd1) && (c <= 8'd4)) begin
      m_reg[int'(c) - 1] = {h, l};
      exp_upd++;
      exp_acks.push_back(8'h06);
    end else begin
      exp_err++;
      exp_acks.push_back(8'h15);
    end
    return 1'b1;
  endfunction

  function automatic void model_reset();
    mfrm.delete();
    for (int i = 0; i < 4; i++) m_reg[i] = 16'h0000;
  endfunction

  // Transmitter: accepts a request by dropping send_rdy for a few cycles.
  initial begin
    forever begin
      @(negedge clk_in);
      if (tx_auto) begin
        if (tx_busy > 0) begin
          tx_busy--;
          if (tx_busy == 0) send_rdy = 1'b1;
        end else if (send && send_rdy) begin
          got_acks.push_back(send_data);
          send_rdy = 1'b0;
          tx_busy  = 4;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_in);
      if (param_upd) upd_cnt++;
      if (frame_err) err_cnt++;
      if (param_upd && frame_err) both_cnt++;
      if (send) send_cycles++;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [7:0] b, input int hold, input int gap);
    bit done;
    int w;
    @(negedge clk_in);
    rx_byte = b;
    rx_rdy  = 1'b1;
    repeat (hold) @(negedge clk_in);
    rx_rdy = 1'b0;
    done = model_byte(b);
    repeat (gap) @(negedge clk_in);
    if (done && tx_auto) begin
      w = 0;
      while ((got_acks.size() < exp_acks.size()) && (w < 300)) begin
        @(negedge clk_in);
        w++;
      end
      if (w >= 300) begin
        assert_cnt++; fail_cnt++;
        $display("[TB] FAIL ack_wait: got %0d acks, required %0d", got_acks.size(), exp_acks.size());
      end
      repeat (8) @(negedge clk_in);
    end
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l, input logic [7:0] s);
    applyStimulus(8'hA5, 16, 4);
    applyStimulus(c, 16, 4);
    applyStimulus(h, 16, 4);
    applyStimulus(l, 16, 4);
    applyStimulus(s, 16, 4);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b0; rx_rdy = 1'b0; rx_byte = 8'h00; send_rdy = 1'b1;
    repeat (3) @(negedge clk_in);
    reset = 1'b1;
    model_reset();
    @(negedge clk_in);
    assert_cnt++;
    if ({kp, ki, kd, setpoint} !== 64'h0) begin
      fail_cnt++; $display("[TB] FAIL reset_regs: got %h required 0", {kp, ki, kd, setpoint});
    end
    assert_cnt++;
    if ({send, send_data, param_upd, frame_err} !== 11'h0) begin
      fail_cnt++; $display("[TB] FAIL reset_outs: got %h required 0", {send, send_data, param_upd, frame_err});
    end
  endtask

  task automatic test_kp_write();
    send_frame(8'h01, 8'h12, 8'h34, 8'h27);
    assert_cnt++;
    if ({kp, ki, kd, setpoint} !== {16'h1234, 16'h0, 16'h0, 16'h0}) begin
      fail_cnt++; $display("[TB] FAIL kp_write_regs: got %h required %h", {kp, ki, kd, setpoint}, {16'h1234, 48'h0});
    end
    assert_cnt++;
    if (upd_cnt !== 1 || err_cnt !== 0) begin
      fail_cnt++; $display("[TB] FAIL kp_write_pulses: got upd=%0d err=%0d required upd=1 err=0", upd_cnt, err_cnt);
    end
    assert_cnt++;
    if (got_acks.size() != 1 || send_data !== 8'h06) begin
      fail_cnt++; $display("[TB] FAIL kp_write_ack: got %0d acks data=%h required 1 ack 06", got_acks.size(), send_data);
    end
  endtask

  task automatic test_leading_garbage();
    logic [7:0] seq [7];
    seq = '{8'h00, 8'hFF, 8'hA5, 8'h03, 8'hFF, 8'hFE, 8'h02};
    for (int i = 0; i < 7; i++) applyStimulus(seq[i], 16, 4);
    assert_cnt++;
    if ({kp, ki, kd, setpoint} !== {m_reg[0], m_reg[1], m_reg[2], m_reg[3]} || kd !== 16'hFFFE) begin
      fail_cnt++; $display("[TB] FAIL garbage_regs: got %h required %h", {kp, ki, kd, setpoint}, {m_reg[0], m_reg[1], m_reg[2], m_reg[3]});
    end
    assert_cnt++;
    if (upd_cnt !== 2 || err_cnt !== 0) begin
      fail_cnt++; $display("[TB] FAIL garbage_pulses: got upd=%0d err=%0d required upd=2 err=0", upd_cnt, err_cnt);
    end
    assert_cnt++;
    if (got_acks.size() != 2 || got_acks[1] !== 8'h06) begin
      fail_cnt++; $display("[TB] FAIL garbage_ack: got %0d acks, required 2 with last 06", got_acks.size());
    end
  endtask

  task automatic test_nak();
    send_frame(8'h02, 8'h00, 8'h10, 8'h00);
    assert_cnt++;
    if (err_cnt !== exp_err || upd_cnt !== exp_upd || got_acks[$] !== 8'h15) begin
      fail_cnt++; $display("[TB] FAIL bad_csum: got err=%0d upd=%0d ack=%h required err=%0d upd=%0d ack=15", err_cnt, upd_cnt, got_acks[$], exp_err, exp_upd);
    end
    send_frame(8'h07, 8'h00, 8'h00, 8'h07);
    assert_cnt++;
    if (err_cnt !== exp_err || upd_cnt !== exp_upd || got_acks[$] !== 8'h15 || send_data !== 8'h15) begin
      fail_cnt++; $display("[TB] FAIL bad_cmd: got err=%0d upd=%0d ack=%h required err=%0d upd=%0d ack=15", err_cnt, upd_cnt, got_acks[$], exp_err, exp_upd);
    end
    assert_cnt++;
    if ({kp, ki, kd, setpoint} !== {m_reg[0], m_reg[1], m_reg[2], m_reg[3]}) begin
      fail_cnt++; $display("[TB] FAIL nak_regs: got %h required %h", {kp, ki, kd, setpoint}, {m_reg[0], m_reg[1], m_reg[2], m_reg[3]});
    end
  endtask

  task automatic test_timeout();
    int n;
    int err0;
    int sc0;
    err0 = err_cnt;
    sc0  = send_cycles;
    applyStimulus(8'hA5, 16, 4);
    applyStimulus(8'h04, 16, 4);
    n = 0;
    while (err_cnt == err0 && n < 300) begin
      @(negedge clk_in);
      n++;
    end
    mfrm.delete();
    exp_err++;
    assert_cnt++;
    if ((n + 20) < TMO - 3 || (n + 20) > TMO + 4) begin
      fail_cnt++; $display("[TB] FAIL timeout_latency: got %0d cycles after last strobe, required about %0d", n + 20, TMO);
    end
    repeat (5) @(negedge clk_in);
    assert_cnt++;
    if (err_cnt !== exp_err || send_cycles !== sc0) begin
      fail_cnt++; $display("[TB] FAIL timeout_pulse: got err=%0d send_cycles=%0d required err=%0d send_cycles=%0d", err_cnt, send_cycles, exp_err, sc0);
    end
    send_frame(8'h04, 8'h00, 8'h64, 8'h60);
    assert_cnt++;
    if (setpoint !== 16'h0064 || setpoint !== m_reg[3]) begin
      fail_cnt++; $display("[TB] FAIL timeout_recover: got setpoint=%h required 0064", setpoint);
    end
  endtask

  task automatic test_reset_midframe();
    int u0;
    int e0;
    u0 = upd_cnt;
    e0 = err_cnt;
    applyStimulus(8'hA5, 16, 4);
    applyStimulus(8'h01, 16, 4);
    applyStimulus(8'h12, 16, 4);
    do_reset();
    @(negedge clk_in);
    assert_cnt++;
    if ({kp, ki, kd, setpoint} !== 64'h0 || send !== 1'b0) begin
      fail_cnt++; $display("[TB] FAIL midframe_reset: got regs=%h send=%b required 0/0", {kp, ki, kd, setpoint}, send);
    end
    assert_cnt++;
    if (upd_cnt !== u0 || err_cnt !== e0) begin
      fail_cnt++; $display("[TB] FAIL midframe_pulses: got upd=%0d err=%0d required %0d %0d", upd_cnt, err_cnt, u0, e0);
    end
    send_frame(8'h01, 8'h00, 8'h05, 8'h04);
    assert_cnt++;
    if ({kp, ki, kd, setpoint} !== {16'h0005, 48'h0}) begin
      fail_cnt++; $display("[TB] FAIL midframe_recover: got %h required %h", {kp, ki, kd, setpoint}, {16'h0005, 48'h0});
    end
  endtask

  task automatic test_ack_stall();
    int sc0;
    int n;
    repeat (10) @(negedge clk_in);
    tx_auto  = 1'b0;
    send_rdy = 1'b0;
    sc0 = send_cycles;
    send_frame(8'h02, 8'hAB, 8'hCD, 8'h64);
    void'(exp_acks.pop_back());
    repeat (120) @(negedge clk_in);
    send_rdy = 1'b1;
    repeat (10) @(negedge clk_in);
    assert_cnt++;
    if (send_cycles !== sc0 || ki !== 16'hABCD || err_cnt !== exp_err) begin
      fail_cnt++; $display("[TB] FAIL ack_dropped: got send_cycles=%0d ki=%h err=%0d required %0d ABCD %0d", send_cycles, ki, err_cnt, sc0, exp_err);
    end
    send_rdy = 1'b0;
    send_frame(8'h03, 8'h00, 8'h11, 8'h12);
    repeat (20) @(negedge clk_in);
    assert_cnt++;
    if (send_cycles !== sc0) begin
      fail_cnt++; $display("[TB] FAIL ack_held_low: got send_cycles=%0d required %0d", send_cycles, sc0);
    end
    send_rdy = 1'b1;
    n = 0;
    while (send !== 1'b1 && n < 10) begin
      @(negedge clk_in);
      n++;
    end
    assert_cnt++;
    if (send !== 1'b1 || send_data !== 8'h06) begin
      fail_cnt++; $display("[TB] FAIL ack_release: got send=%b data=%h required 1 06", send, send_data);
    end
    tx_auto = 1'b1;
    repeat (15) @(negedge clk_in);
    assert_cnt++;
    if (got_acks.size() != exp_acks.size() || got_acks[$] !== 8'h06 || send !== 1'b0) begin
      fail_cnt++; $display("[TB] FAIL ack_complete: got %0d acks last=%h send=%b required %0d acks 06 0", got_acks.size(), got_acks[$], send, exp_acks.size());
    end
  endtask

  task automatic test_random();
    logic [7:0] c, h, l, s, g;
    int ng;
    for (int f = 0; f < 20; f++) begin
      ng = $urandom_range(0, 2);
      for (int i = 0; i < ng; i++) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h5A;
        applyStimulus(g, $urandom_range(1, 16), $urandom_range(1, 4));
      end
      case ($urandom_range(0, 5))
        1: c = 8'h01;
        2: c = 8'h02;
        3: c = 8'h03;
        4: c = 8'h04;
        default: c = 8'($urandom_range(0, 255));
      endcase
      h = 8'($urandom_range(0, 255));
      l = 8'($urandom_range(0, 255));
      s = c ^ h ^ l;
      if ($urandom_range(0, 4) == 0) s = s ^ 8'($urandom_range(1, 255));
      applyStimulus(8'hA5, $urandom_range(1, 16), $urandom_range(1, 4));
      applyStimulus(c, $urandom_range(1, 16), $urandom_range(1, 4));
      applyStimulus(h, $urandom_range(1, 16), $urandom_range(1, 4));
      applyStimulus(l, $urandom_range(1, 16), $urandom_range(1, 4));
      applyStimulus(s, $urandom_range(1, 16), $urandom_range(1, 4));
      assert_cnt++;
      if ({kp, ki, kd, setpoint} !== {m_reg[0], m_reg[1], m_reg[2], m_reg[3]}) begin
        fail_cnt++; $display("[TB] FAIL random_regs[%0d]: got %h required %h", f, {kp, ki, kd, setpoint}, {m_reg[0], m_reg[1], m_reg[2], m_reg[3]});
      end
      assert_cnt++;
      if (got_acks.size() != exp_acks.size() || got_acks[$] !== exp_acks[$]) begin
        fail_cnt++; $display("[TB] FAIL random_ack[%0d]: got %0d acks last=%h required %0d last=%h", f, got_acks.size(), got_acks[$], exp_acks.size(), exp_acks[$]);
      end
      assert_cnt++;
      if (upd_cnt !== exp_upd || err_cnt !== exp_err) begin
        fail_cnt++; $display("[TB] FAIL random_pulses[%0d]: got upd=%0d err=%0d required %0d %0d", f, upd_cnt, err_cnt, exp_upd, exp_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_kp_write();
    test_leading_garbage();
    test_nak();
    test_timeout();
    test_reset_midframe();
    test_ack_stall();
    test_random();
    assert_cnt++;
    if (both_cnt !== 0) begin
      fail_cnt++; $display("[TB] FAIL pulse_exclusive: got %0d overlapping cycles, required 0", both_cnt);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
